mux4_rr_collector: RTL and testbench
====================================

// Module: mux4_rr_collector
// PURPOSE
//  4-to-1 stream collector: merges four valid/ready input channels into one
//  registered output stream. A round-robin arbiter picks the channel; the
//  output carries the source index. It is the inverse of the 1-to-4 demux
//  path: it gathers per-channel traffic back onto a single shared bus.
// PARAMETERS
//  WIDTH   8   data width of each channel and of the output
// PORTS
//  clk        in   1          rising-edge clock
//  rst_n      in   1          asynchronous active-low reset
//  in_valid   in   4          per-channel valid; bit i = channel i
//  in_data    in   4*WIDTH    channel i data at [i*WIDTH +: WIDTH]
//  in_ready   out  4          per-channel accept; at most one bit high
//  out_valid  out  1          output register holds a word
//  out_data   out  WIDTH      registered word
//  out_sel    out  2          index of the channel that supplied out_data
//  out_ready  in   1          downstream accept
// BEHAVIOUR
//  - Reset (async assert, released on clk): out_valid=0, out_data=0,
//    out_sel=0, last-grant pointer ptr=3, so channel 0 has top priority first.
//  - Transfers: input i transfers when in_valid[i] & in_ready[i].
//    The output transfers when out_valid & out_ready.
//  - States:
//    - EMPTY (out_valid=0): go to FULL on any input transfer.
//    - FULL (out_valid=1):
//      - out_ready=0 -> stay FULL.
//      - out_ready=1 and a new input transfers the same cycle -> stay FULL.
//      - out_ready=1 and no input transfers -> go to EMPTY.
//  - load_en = ~out_valid | out_ready (combinational). It permits a same-cycle
//    drain+refill, giving 1 word/clk throughput.
//  - Grant: when load_en=1, select the first channel with in_valid set,
//    searching ptr+1, ptr+2, ptr+3, ptr (mod 4).
//    - in_ready = one-hot of that channel; 4'b0000 if load_en=0 or no valid.
//    - in_ready is combinational from in_valid, ptr and out_valid/out_ready.
//      It never depends on in_data.
//  - On an input transfer from channel g:
//    - next clk: out_data <= in_data[g], out_sel <= g, out_valid <= 1, ptr <= g.
//    - ptr does not change without a transfer.
//  - Latency: input accepted at edge N appears on out_* immediately after
//    edge N (1 cycle).
//  - Stability: while out_valid & ~out_ready, out_data and out_sel hold and
//    in_ready=0.
//  - A sole requester is granted every cycle; no fairness penalty.
//  - Mod-4 wrap: ptr=3 searches 0,1,2,3; ptr=2 searches 3,0,1,2.
//  - in_valid deasserting without a handshake is tolerated; the arbiter
//    re-evaluates every cycle. This is not a protocol error here.
//  - Reset mid-operation discards the held word and any pending grant.
//    in_ready=0 while rst_n=0.
//  - No combinational path from in_* to out_*. out_ready reaches in_ready
//    only via load_en.
// TESTING
//  1. Reset -> out_valid=0, out_data=0, out_sel=0, in_ready=0000.
//  2. in_valid=1111 held, data ch i=8'hA0+i, out_ready=1:
//     - out_sel sequence 0,1,2,3,0.
//     - out_data A0,A1,A2,A3,A0, one per clk.
//  3. Only ch2 valid (8'h55), out_ready=1 for 3 clk:
//     - in_ready=0100 each cycle.
//     - 3 words of 55 with out_sel=2.
//  4. Word from ch1 (8'h3C) held with out_ready=0 for 4 clk, ch0/ch3 valid:
//     - out_data=3C and out_sel=1 stable; in_ready=0000.
//     - On out_ready=1, grant goes to ch3, then ch0.
//  5. in_valid=1010 after a ch1 grant:
//     - grants alternate 3,1,3,1; channels 0 and 2 never get in_ready.
//  6. Assert rst_n=0 mid-stream with out_valid=1:
//     - out_valid=0 immediately, asynchronously.
//     - After release with in_valid=1111, first grant is ch0.

Source files
------------

// File: rtl/mux4_rr_collector.sv
// Four valid/ready channels merged onto one registered output stream.
// A round-robin arbiter picks the channel, and the output also carries the source index.
//
//   state    | meaning
//   ST_EMPTY | output register empty, out_valid=0
//   ST_FULL  | output register holds a word, out_valid=1
module mux4_rr_collector #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         in_valid,
  input  logic [4*WIDTH-1:0] in_data,
  output logic [3:0]         in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [1:0]         out_sel,
  input  logic               out_ready
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [1:0]         r_ptr;
  logic [WIDTH-1:0]   r_data;
  logic [1:0]         r_sel;

  logic               w_load_en;
  logic               w_grant_any;
  logic [1:0]         w_grant_idx;
  logic [1:0]         w_cand;
  logic               w_xfer;

  assign w_load_en = ~out_valid | out_ready;

  // Search ptr+1, ptr+2, ptr+3, ptr; the first valid channel wins.
  always_comb begin
    w_grant_any = 1'b0;
    w_grant_idx = 2'd0;
    w_cand      = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      w_cand = r_ptr + 2'(k);
      if (!w_grant_any && in_valid[w_cand]) begin
        w_grant_any = 1'b1;
        w_grant_idx = w_cand;
      end
    end
  end

  always_comb begin
    in_ready = 4'b0000;
    if (rst_n && w_load_en && w_grant_any) begin
      in_ready[w_grant_idx] = 1'b1;
    end
  end

  assign w_xfer = |(in_valid & in_ready);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: if (w_xfer) w_state_nxt = ST_FULL;
      ST_FULL:  if (out_ready && !w_xfer) w_state_nxt = ST_EMPTY;
      default:  w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // The pointer moves only on a real transfer, so a dropped request costs nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr  <= 2'd3;
      r_data <= '0;
      r_sel  <= 2'd0;
    end else if (w_xfer) begin
      r_ptr  <= w_grant_idx;
      r_data <= in_data[w_grant_idx*WIDTH +: WIDTH];
      r_sel  <= w_grant_idx;
    end
  end

  assign out_valid = (r_state == ST_FULL);
  assign out_data  = r_data;
  assign out_sel   = r_sel;

endmodule

// File: tb/tb_mux4_rr_collector.sv
// Directed and random checks of mux4_rr_collector against a behavioural round-robin model.
module tb_mux4_rr_collector;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [3:0]     in_valid;
  logic [4*W-1:0] in_data;
  logic [3:0]     in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [1:0]     out_sel;
  logic           out_ready;

  int n_err = 0;
  int n_chk = 0;

  int m_valid;
  int m_data;
  int m_sel;
  int m_ptr;

  mux4_rr_collector #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] ref_grant(input int ptr, input logic [3:0] v,
                                           input int mvalid, input logic ordy);
    if (mvalid != 0 && !ordy) return 4'b0000;
    for (int off = 1; off <= 4; off++) begin
      int c;
      c = (ptr + off) % 4;
      if (v[c]) return 4'(1 << c);
    end
    return 4'b0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0;
    m_data  = 0;
    m_sel   = 0;
    m_ptr   = 3;
  endtask

  // One clock: check in_ready before the edge, advance the model, check outputs after it.
  task automatic cycle(input string tag);
    logic [3:0] er;
    int         g;
    int         gdata;
    #1;
    er = ref_grant(m_ptr, in_valid, m_valid, out_ready);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(er));
    g = -1;
    for (int c = 0; c < 4; c++) if (er[c]) g = c;
    gdata = (g >= 0) ? int'(in_data[g*W +: W]) : 0;
    @(posedge clk);
    #1;
    if (g >= 0) begin
      m_valid = 1;
      m_sel   = g;
      m_ptr   = g;
      m_data  = gdata;
    end else if (out_ready) begin
      m_valid = 0;
    end
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
    chk({tag, ".out_data"},  32'(out_data),  32'(m_data));
    chk({tag, ".out_sel"},   32'(out_sel),   32'(m_sel));
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 4'b0000;
    in_data   = '0;
    out_ready = 1'b0;
    model_reset();

    // Reset values
    #12;
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out_data",  32'(out_data),  32'd0);
    chk("rst.out_sel",   32'(out_sel),   32'd0);
    chk("rst.in_ready",  32'(in_ready),  32'd0);
    rst_n = 1'b1;

    // All channels valid, full throughput
    in_valid  = 4'b1111;
    in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle("rr4");
      chk("rr4.sel_seq",  32'(out_sel),  32'(i % 4));
      chk("rr4.data_seq", 32'(out_data), 32'(8'hA0 + (i % 4)));
    end

    // Sole requester granted every cycle
    in_valid = 4'b0100;
    in_data  = {8'h00, 8'h55, 8'h00, 8'h00};
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("solo.in_ready", 32'(in_ready), 32'h4);
      cycle("solo");
      chk("solo.data", 32'(out_data), 32'h55);
      chk("solo.sel",  32'(out_sel),  32'd2);
    end

    // Backpressure holds the ch1 word
    in_valid = 4'b0010;
    in_data  = {8'hD3, 8'h00, 8'h3C, 8'hD0};
    cycle("bp.load");
    in_valid  = 4'b1001;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle("bp.hold");
      chk("bp.hold_data",  32'(out_data), 32'h3C);
      chk("bp.hold_sel",   32'(out_sel),  32'd1);
      chk("bp.hold_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    cycle("bp.rel");
    chk("bp.rel_sel1", 32'(out_sel), 32'd3);
    cycle("bp.rel");
    chk("bp.rel_sel2", 32'(out_sel), 32'd0);

    // Two requesters alternate
    in_valid = 4'b0010;
    cycle("alt.pre");
    in_valid = 4'b1010;
    in_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int i = 0; i < 4; i++) begin
      cycle("alt");
      chk("alt.sel", 32'(out_sel), (i % 2 == 0) ? 32'd3 : 32'd1);
    end

    // Reset while holding a word
    out_ready = 1'b0;
    in_valid  = 4'b1111;
    cycle("mrst.fill");
    chk("mrst.full", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("mrst.out_valid", 32'(out_valid), 32'd0);
    chk("mrst.in_ready",  32'(in_ready),  32'd0);
    chk("mrst.out_data",  32'(out_data),  32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    cycle("mrst.first");
    chk("mrst.first_sel", 32'(out_sel), 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      in_valid  = 4'($urandom);
      in_data   = 32'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle("rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
